// File: rtl/l3_pkg.sv
// rtl/l3_pkg.sv - shared state type and address geometry for the L3 instruction fill responder
package l3_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, RESPOND} l3_state_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_NUM_SETS   = 1024;

    function automatic int calc_idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Lines hold one 32-bit word, so the two byte-offset bits are neither index nor tag.
    function automatic int calc_tag_bits(input int addr_width, input int num_sets);
        return addr_width - $clog2(num_sets) - 2;
    endfunction

    localparam int IDX_BITS = calc_idx_bits(DEF_NUM_SETS);
    localparam int TAG_BITS = calc_tag_bits(DEF_ADDR_WIDTH, DEF_NUM_SETS);

endpackage

// File: rtl/l3_tag_data_ram.sv
// rtl/l3_tag_data_ram.sv - direct-mapped tag/data store with registered read and resettable valid bits
module l3_tag_data_ram #(
    parameter int NUM_SETS   = 1024,
    parameter int IDX_BITS   = 10,
    parameter int TAG_BITS   = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_BITS-1:0]   rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_BITS-1:0]   wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [TAG_BITS+DATA_WIDTH-1:0] lines [NUM_SETS];
    logic [NUM_SETS-1:0]            valid;

    // Tag/data storage has no reset so it can map onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[wr_idx] <= {wr_tag, wr_data};
        end
        {rd_tag, rd_data} <= lines[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
            end
            rd_valid <= valid[rd_idx];
        end
    end

endmodule

// File: rtl/l3_instr_fill_responder.sv
// rtl/l3_instr_fill_responder.sv - L3 responder serving L2 instruction misses, filling from memory on an L3 miss
module l3_instr_fill_responder
    import l3_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l2_miss_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  l3_cache_valid_o,
    output logic [DATA_WIDTH-1:0] l3_cache_data_o,
    output logic                  l3_busy_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [15:0]           hit_count_o,
    output logic [15:0]           miss_count_o
);

    localparam int IDX = calc_idx_bits(NUM_SETS);
    localparam int TAG = calc_tag_bits(ADDR_WIDTH, NUM_SETS);

    l3_state_e             state;
    l3_state_e             state_nx;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  mem_req_q;
    logic [15:0]           hit_count_q;
    logic [15:0]           miss_count_q;
    logic                  busy;

    logic                  rd_valid;
    logic [TAG-1:0]        rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [IDX-1:0]        rd_idx;
    logic                  lookup_hit;
    logic                  fill;
    logic                  unused_req_offset;

    // The read is launched at the accepting edge so LOOKUP already sees the set.
    assign rd_idx     = (state == IDLE) ? addr_i[IDX+1:2] : req_addr_q[IDX+1:2];
    assign lookup_hit = rd_valid && (rd_tag == req_addr_q[ADDR_WIDTH-1:IDX+2]);
    assign fill       = (state == MEM_WAIT) && mem_valid_i && !rst;
    assign unused_req_offset = ^req_addr_q[1:0];

    l3_tag_data_ram #(
        .NUM_SETS   (NUM_SETS),
        .IDX_BITS   (IDX),
        .TAG_BITS   (TAG),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill),
        .wr_idx   (req_addr_q[IDX+1:2]),
        .wr_tag   (req_addr_q[ADDR_WIDTH-1:IDX+2]),
        .wr_data  (mem_data_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        case (state)
            IDLE:     if (l2_miss_i) state_nx = LOOKUP;
            LOOKUP:   state_nx = lookup_hit ? RESPOND : MEM_WAIT;
            MEM_WAIT: if (mem_valid_i) state_nx = RESPOND;
            RESPOND:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q   <= '0;
            resp_data_q  <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            valid_q   <= (state == RESPOND);
            data_q    <= (state == RESPOND) ? resp_data_q : '0;
            mem_req_q <= (state == MEM_WAIT) && !mem_valid_i;
            if (state == IDLE && l2_miss_i) begin
                req_addr_q <= addr_i;
            end
            if (state == LOOKUP) begin
                if (lookup_hit) begin
                    resp_data_q <= rd_data;
                    if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
                end else if (miss_count_q != 16'hFFFF) begin
                    miss_count_q <= miss_count_q + 16'd1;
                end
            end
            if (fill) begin
                resp_data_q <= mem_data_i;
            end
        end
    end

    assign l3_cache_valid_o = valid_q;
    assign l3_cache_data_o  = data_q;
    assign l3_busy_o        = busy;
    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign hit_count_o      = hit_count_q;
    assign miss_count_o     = miss_count_q;

endmodule

// File: tb/tb_l3_instr_fill_responder.sv
// tb/tb_l3_instr_fill_responder.sv - randomized self-checking bench with a transaction-level L3 model
module tb_l3_instr_fill_responder;

    localparam int NS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        l2_miss_i;
    logic [31:0] addr_i;
    logic        l3_cache_valid_o;
    logic [31:0] l3_cache_data_o;
    logic        l3_busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic [15:0] hit_count_o;
    logic [15:0] miss_count_o;

    always #5 clk = ~clk;

    l3_instr_fill_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_SETS   (NS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .l2_miss_i        (l2_miss_i),
        .addr_i           (addr_i),
        .l3_cache_valid_o (l3_cache_valid_o),
        .l3_cache_data_o  (l3_cache_data_o),
        .l3_busy_o        (l3_busy_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_valid_i      (mem_valid_i),
        .mem_data_i       (mem_data_i),
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int accepted = 0;

    // Expected outputs for the cycle after the next rising edge.
    logic        e_valid, e_busy, e_mem_req;
    logic [31:0] e_data, e_mem_addr;
    logic [15:0] e_hits, e_misses;
    bit          cmp_en     = 1'b0;
    bit          hit_cmp_en = 1'b1;

    bit          m_valid [NS];
    logic [19:0] m_tag   [NS];
    logic [31:0] m_data  [NS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #3;
        if (l3_cache_valid_o === 1'b1) pulses++;
        if (cmp_en) begin
            check("valid", {31'b0, l3_cache_valid_o}, {31'b0, e_valid});
            check("data", l3_cache_data_o, e_data);
            check("busy", {31'b0, l3_busy_o}, {31'b0, e_busy});
            check("mem_req", {31'b0, mem_req_o}, {31'b0, e_mem_req});
            if (e_mem_req) check("mem_addr", mem_addr_o, e_mem_addr);
            if (hit_cmp_en) check("hit_count", {16'b0, hit_count_o}, {16'b0, e_hits});
            check("miss_count", {16'b0, miss_count_o}, {16'b0, e_misses});
        end
    end

    function automatic logic [15:0] sat(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    task automatic set_exp(input logic v, input logic [31:0] d, input logic b,
                           input logic mr, input logic [31:0] ma);
        e_valid = v; e_data = d; e_busy = b; e_mem_req = mr; e_mem_addr = ma;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; l2_miss_i = 1'b0; mem_valid_i = 1'b0;
        e_hits = '0; e_misses = '0;
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        set_exp(1'b0, '0, 1'b0, 1'b0, '0);
        cmp_en = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic idle(input bit spur_mem);
        l2_miss_i = 1'b0;
        mem_valid_i = spur_mem;
        mem_data_i = $urandom;
        set_exp(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        mem_valid_i = 1'b0;
    endtask

    // One complete request, timed from the documented latencies; delay = cycles mem_req is high before data.
    task automatic request(input logic [31:0] a, input int delay, input logic [31:0] md,
                           input bit spur, input bit do_force);
        int          idx;
        logic [19:0] tg;
        logic [31:0] al;
        bit          hit;
        idx = int'(a[11:2]);
        tg  = a[31:12];
        al  = {a[31:2], 2'b00};
        hit = m_valid[idx] && (m_tag[idx] == tg);
        accepted++;
        addr_i = a; l2_miss_i = 1'b1; mem_valid_i = 1'b0;
        set_exp(1'b0, '0, 1'b1, 1'b0, al);
        tick();
        l2_miss_i   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_valid_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_data_i  = $urandom;
        if (hit) e_hits = sat(e_hits);
        else     e_misses = sat(e_misses);
        if (do_force) force dut.hit_count_q = 16'hFFF0;
        set_exp(1'b0, '0, 1'b1, 1'b0, al);
        tick();
        if (do_force) release dut.hit_count_q;
        if (hit) begin
            l2_miss_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_valid_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            set_exp(1'b1, m_data[idx], 1'b0, 1'b0, al);
            tick();
        end else begin
            for (int i = 0; i < delay; i++) begin
                l2_miss_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_valid_i = 1'b0;
                set_exp(1'b0, '0, 1'b1, 1'b1, al);
                tick();
            end
            mem_valid_i = 1'b1; mem_data_i = md;
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = md;
            set_exp(1'b0, '0, 1'b1, 1'b0, al);
            tick();
            l2_miss_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_valid_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_data_i = $urandom;
            set_exp(1'b1, md, 1'b0, 1'b0, al);
            tick();
        end
        l2_miss_i = 1'b0; mem_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [15:0] saved_misses;
        rst = 1'b1; l2_miss_i = 1'b0; addr_i = '0; mem_valid_i = 1'b0; mem_data_i = '0;
        do_reset(3);
        check("reset_hits", {16'b0, hit_count_o}, 32'd0);
        check("reset_valid", {31'b0, l3_cache_valid_o}, 32'd0);
        idle(1'b0);

        // Cold miss, then hit, then a conflicting fill evicting the line.
        request(32'h0000_0104, 5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("cold_data", l3_cache_data_o, 32'hDEAD_BEEF);
        check("cold_misses", {16'b0, miss_count_o}, 32'd1);
        request(32'h0000_0104, 0, 32'h0, 1'b0, 1'b0);
        check("hit_data", l3_cache_data_o, 32'hDEAD_BEEF);
        check("hit_count", {16'b0, hit_count_o}, 32'd1);
        request(32'h0000_1104, 3, 32'h1234_5678, 1'b0, 1'b0);
        check("conflict_data", l3_cache_data_o, 32'h1234_5678);
        request(32'h0000_0104, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
        check("evict_misses", {16'b0, miss_count_o}, 32'd3);
        check("evict_data", l3_cache_data_o, 32'hCAFE_F00D);
        idle(1'b0);

        // Reset while waiting on memory, with a data beat arriving in the reset cycle.
        accepted++;
        addr_i = 32'h0000_2208; l2_miss_i = 1'b1;
        set_exp(1'b0, '0, 1'b1, 1'b0, 32'h0000_2208);
        tick();
        l2_miss_i = 1'b0; e_misses = sat(e_misses);
        tick();
        set_exp(1'b0, '0, 1'b1, 1'b1, 32'h0000_2208);
        tick();
        tick();
        accepted--;
        mem_valid_i = 1'b1; mem_data_i = 32'h5555_AAAA;
        do_reset(2);
        check("post_reset_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("post_reset_misses", {16'b0, miss_count_o}, 32'd0);
        idle(1'b0);
        request(32'h0000_2208, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
        check("rereq_misses", {16'b0, miss_count_o}, 32'd1);
        check("rereq_hits", {16'b0, hit_count_o}, 32'd0);

        // Spurious memory beat in IDLE must not fill set 0x10; spurious l2_miss while busy is ignored.
        idle(1'b1);
        mem_valid_i = 1'b1; mem_data_i = 32'h7777_7777;
        set_exp(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        mem_valid_i = 1'b0;
        request(32'h0000_0040, 4, 32'hA5A5_0040, 1'b1, 1'b0);
        check("spur_misses", {16'b0, miss_count_o}, 32'd2);

        // Random traffic over a few sets and tags so hits, misses and evictions all occur.
        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 2)) << 12) | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
            request(a, $urandom_range(1, 6), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Saturation: preload near the top, then drive enough hits to pin the counter.
        request(32'h0000_0104, 2, 32'h0104_0104, 1'b0, 1'b0);
        saved_misses = e_misses;
        hit_cmp_en = 1'b0;
        request(32'h0000_0104, 0, 32'h0, 1'b0, 1'b1);
        repeat (20) request(32'h0000_0104, 0, 32'h0, 1'b0, 1'b0);
        e_hits = 16'hFFFF;
        hit_cmp_en = 1'b1;
        repeat (5) request(32'h0000_0104, 0, 32'h0, 1'b1, 1'b0);
        check("sat_hits", {16'b0, hit_count_o}, 32'h0000_FFFF);
        check("sat_misses", {16'b0, miss_count_o}, {16'b0, saved_misses});
        idle(1'b0);
        idle(1'b0);

        check("pulse_count", pulses, accepted);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
